// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: opcodes, FSM states and
// the instruction-length decode.
package cpu_sequencer_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_OPERAND = 2'd1,
        ST_EXEC    = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    // Opcodes that carry an immediate byte at pc+1.
    function automatic logic is_two_byte(input logic [3:0] op);
        case (op)
            OP_LDI, OP_JMP, OP_JZ, OP_JC: is_two_byte = 1'b1;
            default:                      is_two_byte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_alu8.sv
// Combinational 8-bit add/subtract with carry-or-borrow and zero outputs.
module alu8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero
);

    logic [8:0] wide_s;

    // Nine-bit arithmetic: bit 8 is carry on add and borrow on subtract.
    always_comb begin
        wide_s = 9'h000;
        if (sub) begin
            wide_s = {1'b0, a} - {1'b0, b};
        end else begin
            wide_s = {1'b0, a} + {1'b0, b};
        end
    end

    assign result = wide_s[7:0];
    assign carry  = wide_s[8];
    assign zero   = (wide_s[7:0] == 8'h00);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/operand/execute controller for the 8-bit CPU; owns pc,
// accumulator and Z/C flags and drives the register-file write port.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int RF_AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [PC_W-1:0]  pm_addr,
    input  logic [7:0]       pm_data,
    output logic [RF_AW-1:0] rf_addr,
    output logic             rf_we,
    output logic [7:0]       rf_wdata,
    input  logic [7:0]       rf_rdata,
    output logic [7:0]       acc,
    output logic             flag_z,
    output logic             flag_c,
    output logic             halted
);

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic [7:0]      ir_r;
    logic [7:0]      imm_r;
    logic [7:0]      acc_r;
    logic            z_r;
    logic            c_r;
    logic            halted_r;

    logic [3:0]      op_s;
    logic            sub_s;
    logic [7:0]      alu_res_s;
    logic            alu_c_s;
    logic            alu_z_s;
    logic            rf_we_s;
    logic [7:0]      rf_wdata_s;

    assign op_s  = ir_r[7:4];
    assign sub_s = (op_s == OP_SUB);

    alu8 u_alu (
        .a      (acc_r),
        .b      (rf_rdata),
        .sub    (sub_s),
        .result (alu_res_s),
        .carry  (alu_c_s),
        .zero   (alu_z_s)
    );

    // Write strobe is decoded from state so an async reset removes it at once.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_wdata_s = acc_r;
        if ((state_r == ST_EXEC) && ((op_s == OP_LDI) || (op_s == OP_STA))) begin
            rf_we_s = 1'b1;
        end else begin
            rf_we_s = 1'b0;
        end
        if (op_s == OP_LDI) begin
            rf_wdata_s = imm_r;
        end else begin
            rf_wdata_s = acc_r;
        end
    end

    // Sequencer FSM with the architectural state it updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_FETCH;
            pc_r     <= {PC_W{1'b0}};
            ir_r     <= 8'h00;
            imm_r    <= 8'h00;
            acc_r    <= 8'h00;
            z_r      <= 1'b0;
            c_r      <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (run) begin
                        ir_r    <= pm_data;
                        pc_r    <= pc_r + PC_W'(1'b1);
                        state_r <= is_two_byte(pm_data[7:4]) ? ST_OPERAND : ST_EXEC;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_OPERAND: begin
                    imm_r   <= pm_data;
                    pc_r    <= pc_r + PC_W'(1'b1);
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (op_s)
                        OP_LDA: begin
                            acc_r <= rf_rdata;
                            z_r   <= (rf_rdata == 8'h00);
                        end
                        OP_ADD, OP_SUB: begin
                            acc_r <= alu_res_s;
                            c_r   <= alu_c_s;
                            z_r   <= alu_z_s;
                        end
                        OP_JMP: pc_r <= PC_W'(imm_r);
                        OP_JZ: begin
                            if (z_r) pc_r <= PC_W'(imm_r);
                        end
                        OP_JC: begin
                            if (c_r) pc_r <= PC_W'(imm_r);
                        end
                        OP_HLT:                      halted_r <= 1'b1;
                        OP_NOP, OP_LDI, OP_STA:      ;
                        default:                     ;
                    endcase
                    state_r <= (op_s == OP_HLT) ? ST_HALT : ST_FETCH;
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_FETCH;
            endcase
        end
    end

    assign pm_addr  = pc_r;
    assign rf_addr  = RF_AW'(ir_r[3:0]);
    assign rf_we    = rf_we_s;
    assign rf_wdata = rf_wdata_s;
    assign acc      = acc_r;
    assign flag_z   = z_r;
    assign flag_c   = c_r;
    assign halted   = halted_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level reference model
// predicts register writes and final state; a monitor checks each write.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] pm_addr, pm_data;
    logic [3:0] rf_addr;
    logic       rf_we;
    logic [7:0] rf_wdata, rf_rdata, acc;
    logic       flag_z, flag_c, halted;

    logic [7:0] rom [256];
    logic [7:0] rf  [16];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] npc;
    } wr_t;
    wr_t exp_q[$];

    logic [7:0] m_pc, m_acc;
    logic       m_z, m_c, m_halt;
    logic [7:0] m_reg [16];
    int         m_cycles;

    cpu_sequencer #(.PC_W(8), .RF_AW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .pm_addr  (pm_addr),
        .pm_data  (pm_data),
        .rf_addr  (rf_addr),
        .rf_we    (rf_we),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata),
        .acc      (acc),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    assign pm_data  = rom[pm_addr];
    assign rf_rdata = rf[rf_addr];

    always @(posedge clk) begin
        if (rf_we === 1'b1) rf[rf_addr] <= rf_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every register write must match the next expected entry.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {24'h0, rf_addr, 4'h0}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(rf_addr), 32'(e.a));
                    chk("wr_data", 32'(rf_wdata), 32'(e.d));
                    @(posedge clk);
                    #1;
                    chk("pc_after_wr", 32'(pm_addr), 32'(e.npc));
                end
            end
        end
    end

    // Instruction-level interpreter of the ISA.
    task automatic model_run(input bit push);
        logic [7:0] insn, imm;
        logic [3:0] r;
        logic [8:0] s;
        m_pc = 8'h00; m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0;
        m_halt = 1'b0; m_cycles = 0;
        for (int i = 0; i < 16; i++) m_reg[i] = rf[i];
        for (int n = 0; n < 300 && !m_halt; n++) begin
            insn = rom[m_pc];
            m_pc = m_pc + 8'd1;
            imm  = 8'h00;
            if (insn[7:4] == 4'd1 || insn[7:4] == 4'd6 || insn[7:4] == 4'd7 || insn[7:4] == 4'd8) begin
                imm = rom[m_pc];
                m_pc = m_pc + 8'd1;
                m_cycles += 3;
            end else begin
                m_cycles += 2;
            end
            r = insn[3:0];
            case (insn[7:4])
                4'd1: begin
                    m_reg[r] = imm;
                    if (push) exp_q.push_back('{r, imm, m_pc});
                end
                4'd2: begin m_acc = m_reg[r]; m_z = (m_acc == 8'd0); end
                4'd3: begin
                    m_reg[r] = m_acc;
                    if (push) exp_q.push_back('{r, m_acc, m_pc});
                end
                4'd4: begin
                    s = {1'b0, m_acc} + {1'b0, m_reg[r]};
                    m_c = s[8]; m_acc = s[7:0]; m_z = (m_acc == 8'd0);
                end
                4'd5: begin
                    m_c = (m_acc < m_reg[r]);
                    m_acc = m_acc - m_reg[r];
                    m_z = (m_acc == 8'd0);
                end
                4'd6: m_pc = imm;
                4'd7: if (m_z) m_pc = imm;
                4'd8: if (m_c) m_pc = imm;
                4'd15: m_halt = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    endtask

    task automatic load(input int base, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        rom[base] = b0; rom[base+1] = b1; rom[base+2] = b2; rom[base+3] = b3;
    endtask

    task automatic rand_rf();
        for (int i = 0; i < 16; i++) rf[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pm_addr", 32'(pm_addr), 32'h0);
        chk("rst_acc", 32'(acc), 32'h0);
        chk("rst_flags", {30'h0, flag_z, flag_c}, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_rf_we", 32'(rf_we), 32'h0);
        chk("rst_rf_addr", 32'(rf_addr), 32'h0);
        chk("rst_rf_wdata", 32'(rf_wdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_test(input bit rand_run, output int cyc);
        do_reset();
        model_run(1'b1);
        cyc = 0;
        run = 1'b1;
        while (halted !== 1'b1 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rand_run) run = 1'($urandom_range(0, 1));
        end
        chk("halted", 32'(halted), 32'h1);
        if (!rand_run) chk("halt_cycles", 32'(cyc), 32'(m_cycles));
        chk("final_acc", 32'(acc), 32'(m_acc));
        chk("final_z", 32'(flag_z), 32'(m_z));
        chk("final_c", 32'(flag_c), 32'(m_c));
        chk("final_pc", 32'(pm_addr), 32'(m_pc));
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        for (int i = 0; i < 16; i++) chk("rf_reg", 32'(rf[i]), 32'(m_reg[i]));
    endtask

    task automatic gen_prog();
        int len;
        logic [3:0] op;
        do begin
            clear_rom();
            rand_rf();
            len = $urandom_range(12, 40);
            for (int a = 0; a < len; a++) begin
                op = 4'($urandom_range(0, 14));
                if (op >= 4'd6 && op <= 4'd8 && $urandom_range(0, 3) != 0)
                    op = 4'($urandom_range(1, 5));
                rom[a] = {op, 4'($urandom_range(0, 15))};
            end
            model_run(1'b0);
        end while (!m_halt);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;

        // LDI r0,5A; LDA r0; HLT
        clear_rom(); rand_rf();
        load(0, 8'h10, 8'h5A, 8'h20, 8'hF0);
        run_test(1'b0, cyc);
        chk("t1_cycles", 32'(cyc), 32'd7);
        chk("t1_acc", 32'(acc), 32'h5A);
        chk("t1_z", 32'(flag_z), 32'h0);
        chk("t1_r0", 32'(rf[0]), 32'h5A);

        // ADD with carry-out, then SUB with borrow
        clear_rom(); rand_rf();
        load(0, 8'h12, 8'h20, 8'h13, 8'hF0);
        load(4, 8'h23, 8'h42, 8'h34, 8'h52);
        run_test(1'b0, cyc);
        chk("t2_add_result", 32'(rf[4]), 32'h10);
        chk("t2_acc", 32'(acc), 32'hF0);
        chk("t2_c", 32'(flag_c), 32'h1);
        chk("t2_z", 32'(flag_z), 32'h0);

        // SUB to zero, JZ taken, JC not taken
        clear_rom(); rand_rf();
        load(0, 8'h11, 8'h33, 8'h21, 8'h51);
        load(4, 8'h70, 8'h40, 8'hF0, 8'hF0);
        load(8'h40, 8'h80, 8'h80, 8'hF0, 8'hF0);
        load(8'h80, 8'h15, 8'hEE, 8'hF0, 8'hF0);
        run_test(1'b0, cyc);
        chk("t3_acc", 32'(acc), 32'h00);
        chk("t3_z", 32'(flag_z), 32'h1);
        chk("t3_c", 32'(flag_c), 32'h0);
        chk("t3_pc", 32'(pm_addr), 32'h43);

        // JMP FF, LDI at FF takes its immediate from 00 after pc wrap
        clear_rom(); rand_rf();
        load(0, 8'h77, 8'hF0, 8'h60, 8'hFF);
        rom[8'hFF] = 8'h10;
        run_test(1'b0, cyc);
        chk("t4_r0", 32'(rf[0]), 32'h77);
        chk("t4_pc", 32'(pm_addr), 32'h02);

        // run held low in FETCH stalls everything
        clear_rom(); rand_rf();
        load(0, 8'h10, 8'h12, 8'h20, 8'hF0);
        do_reset();
        model_run(1'b1);
        run = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run = 1'b0;
        chk("t5_pc_before", 32'(pm_addr), 32'h03);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t5_stall_pc", 32'(pm_addr), 32'h03);
            chk("t5_stall_acc", 32'(acc), 32'h12);
            chk("t5_stall_we", 32'(rf_we), 32'h0);
            chk("t5_stall_halt", 32'(halted), 32'h0);
        end
        run = 1'b1;
        cyc = 0;
        while (halted !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t5_resume_cycles", 32'(cyc), 32'd2);
        chk("t5_final_pc", 32'(pm_addr), 32'h04);

        // reset during STA EXEC aborts the write
        clear_rom(); rand_rf();
        load(0, 8'h10, 8'h44, 8'h20, 8'h33);
        rf[3] = 8'hA5;
        do_reset();
        exp_q.push_back('{4'd0, 8'h44, 8'h02});
        run = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_we_in_exec", 32'(rf_we), 32'h1);
        chk("t6_addr_in_exec", 32'(rf_addr), 32'h3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_we_async", 32'(rf_we), 32'h0);
        chk("t6_acc", 32'(acc), 32'h0);
        chk("t6_pc", 32'(pm_addr), 32'h0);
        chk("t6_rf_addr", 32'(rf_addr), 32'h0);
        chk("t6_rf_wdata", 32'(rf_wdata), 32'h0);
        chk("t6_flags_halt", {29'h0, flag_z, flag_c, halted}, 32'h0);
        @(posedge clk);
        #1;
        chk("t6_no_write", 32'(rf[3]), 32'hA5);
        chk("t6_queue", 32'(exp_q.size()), 32'h0);

        // random programs, with run both held high and toggled
        for (int t = 0; t < 20; t++) begin
            gen_prog();
            run_test(t[0], cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
